// File: rtl/local_port_input_buffer_if.sv
// Handshake bundle between the PE injector, the local input buffer
// and the router switch allocator.
interface local_port_input_buffer_if #(
    parameter int dataWidth = 32,
    parameter int ADDR_W    = 2
);
    logic                 ReqUpStr;
    logic [dataWidth-1:0] PacketIn;
    logic                 GntUpStr;
    logic                 UpStrFull;
    logic                 ReqRt;
    logic [dataWidth-1:0] DataRt;
    logic                 GntRt;
    logic [ADDR_W:0]      Occupancy;

    modport master (
        output ReqUpStr, PacketIn, GntRt,
        input  GntUpStr, UpStrFull, ReqRt, DataRt, Occupancy
    );

    modport slave (
        input  ReqUpStr, PacketIn, GntRt,
        output GntUpStr, UpStrFull, ReqRt, DataRt, Occupancy
    );
endinterface

// File: rtl/local_port_input_buffer.sv
// Local input port FIFO of a mesh router: Req/Gnt write side, Req/Gnt pop side.
// Define LOCAL_BUF_STATS_EN to add the PeakOcc / FlitCnt statistics outputs.
module local_port_input_buffer #(
    parameter int dataWidth = 32,
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 2
) (
    input logic clk,
    input logic reset,
    local_port_input_buffer_if.slave bus
`ifdef LOCAL_BUF_STATS_EN
    ,
    output logic [ADDR_W:0] PeakOcc,
    output logic [31:0]     FlitCnt
`endif
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    typedef enum logic {IDLE, GRANTED} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                gnt_q, gnt_d;
    logic                wr_en, rd_en;
    logic [dataWidth-1:0] mem_q [DEPTH];

    always_comb begin
        state_d  = state_q;
        gnt_d    = 1'b0;
        wr_en    = 1'b0;
        rd_en    = bus.GntRt && (count_q != '0);
        unique case (state_q)
            IDLE: begin
                if (bus.ReqUpStr && (count_q != FULL_CNT)) begin
                    wr_en   = 1'b1;
                    gnt_d   = 1'b1;
                    state_d = GRANTED;
                end
            end
            GRANTED: begin
                // request still high here is the same request; never rewrite it
                if (!bus.ReqUpStr) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            gnt_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            gnt_q    <= gnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= bus.PacketIn;
        end
    end

    assign bus.GntUpStr  = gnt_q;
    assign bus.UpStrFull = (count_q == FULL_CNT);
    assign bus.ReqRt     = (count_q != '0);
    assign bus.Occupancy = count_q;
    // memory is uninitialised, so hide it while empty
    assign bus.DataRt    = bus.ReqRt ? mem_q[rd_ptr_q] : '0;

`ifdef LOCAL_BUF_STATS_EN
    logic [ADDR_W:0] peak_q, peak_d;
    logic [31:0]     flit_cnt_q, flit_cnt_d;

    always_comb begin
        peak_d     = (count_d > peak_q) ? count_d : peak_q;
        flit_cnt_d = wr_en ? flit_cnt_q + 32'd1 : flit_cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            peak_q     <= '0;
            flit_cnt_q <= '0;
        end else begin
            peak_q     <= peak_d;
            flit_cnt_q <= flit_cnt_d;
        end
    end

    assign PeakOcc = peak_q;
    assign FlitCnt = flit_cnt_q;
`endif

endmodule
